// File: rtl/ula_arbiter.sv
// ---------------------------------------------------------------------------
// ula_arbiter
//
// Two-port round-robin arbiter and sequencer in front of one registered ULA.
// Each accepted operation is driven onto the ULA inputs. The arbiter waits
// ULA_LATENCY edges for the registered result, then returns it with the
// issuing requester's ID over a valid/ready response channel. Only one
// operation is in flight at a time.
//
// Parameters
//   WIDTH        operand/result width (must match the ULA)
//   ULA_LATENCY  edges from ULA input sample to stable result, legal 1..7
//
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   reqN_valid/reqN_ready   request handshake, N = 0,1 (ready is combinational)
//   reqN_modo/op/a/b        request payload
//   rsp_valid/rsp_ready     response handshake
//   rsp_id                  requester that issued the operation
//   rsp_resultado/carryout/zero  captured ULA outputs
//   ula_modo/op/a/b         registered drive to the ULA
//   ula_resultado/carryout/zero  ULA outputs
//   busy                    high whenever the FSM is outside IDLE
//   stat_cnt0/stat_cnt1     saturating per-requester response counters,
//                           present only when ULA_ARB_STATS_EN is defined
//
// Optional feature macro: ULA_ARB_STATS_EN
// ---------------------------------------------------------------------------
module ula_arbiter #(
   parameter int unsigned WIDTH       = 6,
   parameter int unsigned ULA_LATENCY = 1
) (
   input  logic             clock,
   input  logic             reset,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic             req0_modo,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic             req1_modo,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,

   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_resultado,
   output logic             rsp_carryout,
   output logic             rsp_zero,

   output logic             ula_modo,
   output logic [2:0]       ula_op,
   output logic [WIDTH-1:0] ula_a,
   output logic [WIDTH-1:0] ula_b,
`ifdef ULA_ARB_STATS_EN
   output logic [7:0]       stat_cnt0,
   output logic [7:0]       stat_cnt1,
`endif
   input  logic [WIDTH-1:0] ula_resultado,
   input  logic             ula_carryout,
   input  logic             ula_zero,

   output logic             busy
);

   localparam int unsigned CNT_W = 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   // Wait-counter reload: WAIT lasts ULA_LATENCY cycles after EXEC
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ULA_LATENCY - 1);

   logic [1:0]       state_q,   state_d;
   logic             ptr_q,     ptr_d;      // 1: requester 1 has priority
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             busy_q,    busy_d;

   logic             ula_modo_q, ula_modo_d;
   logic [2:0]       ula_op_q,   ula_op_d;
   logic [WIDTH-1:0] ula_a_q,    ula_a_d;
   logic [WIDTH-1:0] ula_b_q,    ula_b_d;

   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q,    rsp_id_d;
   logic [WIDTH-1:0] rsp_res_q,   rsp_res_d;
   logic             rsp_c_q,     rsp_c_d;
   logic             rsp_z_q,     rsp_z_d;

`ifdef ULA_ARB_STATS_EN
   logic [7:0]       stat0_q, stat0_d;
   logic [7:0]       stat1_q, stat1_d;
`endif

   logic grant0_c;
   logic grant1_c;
   logic in_idle_c;

   // Round-robin grant: a lone requester always wins, the pointer breaks ties
   assign in_idle_c = (state_q == ST_IDLE);
   assign grant0_c  = in_idle_c & req0_valid & (~req1_valid | ~ptr_q);
   assign grant1_c  = in_idle_c & req1_valid & (~req0_valid |  ptr_q);

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      ula_modo_d  = ula_modo_q;
      ula_op_d    = ula_op_q;
      ula_a_d     = ula_a_q;
      ula_b_d     = ula_b_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_res_d   = rsp_res_q;
      rsp_c_d     = rsp_c_q;
      rsp_z_d     = rsp_z_q;
`ifdef ULA_ARB_STATS_EN
      stat0_d     = stat0_q;
      stat1_d     = stat1_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (grant0_c || grant1_c) begin
               if (grant1_c) begin
                  ula_modo_d = req1_modo;
                  ula_op_d   = req1_op;
                  ula_a_d    = req1_a;
                  ula_b_d    = req1_b;
               end else begin
                  ula_modo_d = req0_modo;
                  ula_op_d   = req0_op;
                  ula_a_d    = req0_a;
                  ula_b_d    = req0_b;
               end
               rsp_id_d = grant1_c;
               // Winner drops to lowest priority
               ptr_d    = grant0_c;
               state_d  = ST_EXEC;
            end
         end

         ST_EXEC: begin
            // ULA samples ula_* at the edge closing this cycle
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            if (cnt_q == '0) begin
               rsp_res_d   = ula_resultado;
               rsp_c_d     = ula_carryout;
               rsp_z_d     = ula_zero;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
`ifdef ULA_ARB_STATS_EN
               if (rsp_id_q == 1'b0) begin
                  if (stat0_q != 8'hFF) stat0_d = stat0_q + 8'd1;
               end else begin
                  if (stat1_q != 8'hFF) stat1_d = stat1_q + 8'd1;
               end
`endif
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ptr_q       <= 1'b0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         ula_modo_q  <= 1'b0;
         ula_op_q    <= '0;
         ula_a_q     <= '0;
         ula_b_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_res_q   <= '0;
         rsp_c_q     <= 1'b0;
         rsp_z_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         ula_modo_q  <= ula_modo_d;
         ula_op_q    <= ula_op_d;
         ula_a_q     <= ula_a_d;
         ula_b_q     <= ula_b_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_res_q   <= rsp_res_d;
         rsp_c_q     <= rsp_c_d;
         rsp_z_q     <= rsp_z_d;
      end
   end

`ifdef ULA_ARB_STATS_EN
   // Saturating response counters
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat0_q <= '0;
         stat1_q <= '0;
      end else begin
         stat0_q <= stat0_d;
         stat1_q <= stat1_d;
      end
   end

   assign stat_cnt0 = stat0_q;
   assign stat_cnt1 = stat1_q;
`endif

   assign req0_ready    = grant0_c;
   assign req1_ready    = grant1_c;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_id        = rsp_id_q;
   assign rsp_resultado = rsp_res_q;
   assign rsp_carryout  = rsp_c_q;
   assign rsp_zero      = rsp_z_q;
   assign ula_modo      = ula_modo_q;
   assign ula_op        = ula_op_q;
   assign ula_a         = ula_a_q;
   assign ula_b         = ula_b_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ula_arbiter
//
// Self-checking bench for ula_arbiter (WIDTH=6, ULA_LATENCY=1) with a small
// registered ULA model attached. Directed vectors plus hand-written sequences
// for contention, backpressure and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_ula_arbiter;

   localparam int unsigned WIDTH = 6;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             req0_valid = 1'b0, req1_valid = 1'b0;
   logic             req0_ready, req1_ready;
   logic             req0_modo = 1'b0, req1_modo = 1'b0;
   logic [2:0]       req0_op = '0, req1_op = '0;
   logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic             rsp_valid, rsp_id, rsp_carryout, rsp_zero;
   logic             rsp_ready = 1'b0;
   logic [WIDTH-1:0] rsp_resultado;
   logic             ula_modo;
   logic [2:0]       ula_op;
   logic [WIDTH-1:0] ula_a, ula_b;
   logic [WIDTH-1:0] ula_resultado = '0;
   logic             ula_carryout = 1'b0, ula_zero = 1'b0;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   ula_arbiter #(.WIDTH(WIDTH), .ULA_LATENCY(1)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_modo(req0_modo),
      .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_modo(req1_modo),
      .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_resultado(rsp_resultado), .rsp_carryout(rsp_carryout), .rsp_zero(rsp_zero),
      .ula_modo(ula_modo), .ula_op(ula_op), .ula_a(ula_a), .ula_b(ula_b),
      .ula_resultado(ula_resultado), .ula_carryout(ula_carryout), .ula_zero(ula_zero),
      .busy(busy)
   );

   // Registered ULA model: add/sub with signed overflow, logic AND/OR/XOR
   always_ff @(posedge clock) begin
      logic [WIDTH-1:0] r;
      logic             c;
      r = '0;
      c = 1'b0;
      if (!ula_modo) begin
         if (ula_op == 3'd1) begin
            r = ula_a - ula_b;
            c = (ula_a[WIDTH-1] != ula_b[WIDTH-1]) && (r[WIDTH-1] != ula_a[WIDTH-1]);
         end else begin
            r = ula_a + ula_b;
            c = (ula_a[WIDTH-1] == ula_b[WIDTH-1]) && (r[WIDTH-1] != ula_a[WIDTH-1]);
         end
      end else begin
         case (ula_op)
            3'd1:    r = ula_a | ula_b;
            3'd2:    r = ula_a ^ ula_b;
            default: r = ula_a & ula_b;
         endcase
      end
      ula_resultado <= r;
      ula_carryout  <= c;
      ula_zero      <= (r == '0);
   end

   typedef struct {
      logic             id;
      logic             modo;
      logic [2:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] res;
      logic             c;
      logic             z;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_req(input logic id, input logic v, input vec_t x);
      if (id) begin
         req1_valid = v; req1_modo = x.modo; req1_op = x.op; req1_a = x.a; req1_b = x.b;
      end else begin
         req0_valid = v; req0_modo = x.modo; req0_op = x.op; req0_a = x.a; req0_b = x.b;
      end
   endtask

   // Called just after a rising edge; returns just after the accept edge
   task automatic wait_grant(input logic id, output bit got);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clock);
         if (id ? req1_ready : req0_ready) got = 1'b1;
         else begin @(posedge clock); #1; end
      end
      chk("grant_seen", 32'(got), 32'd1);
      if (got) begin
         chk("other_ready_low", 32'(id ? req0_ready : req1_ready), 32'd0);
         @(posedge clock); #1;
      end
   endtask

   // Counts falling edges after the accept edge until rsp_valid is seen
   task automatic wait_rsp(output int n);
      n = 0;
      for (int i = 1; i <= 12 && n == 0; i++) begin
         @(negedge clock);
         if (rsp_valid) n = i;
      end
   endtask

   task automatic run_op(input vec_t v);
      bit got;
      int n;
      drive_req(v.id, 1'b1, v);
      wait_grant(v.id, got);
      drive_req(v.id, 1'b0, v);
      if (got) begin
         chk("busy_exec", 32'(busy), 32'd1);
         chk("ula_a", 32'(ula_a), 32'(v.a));
         chk("ula_b", 32'(ula_b), 32'(v.b));
         chk("ula_op_modo", {28'd0, ula_modo, ula_op}, {28'd0, v.modo, v.op});
         wait_rsp(n);
         chk("rsp_latency", 32'(n), 32'd3);
         chk("rsp_id", 32'(rsp_id), 32'(v.id));
         chk("rsp_resultado", 32'(rsp_resultado), 32'(v.res));
         chk("rsp_carryout", 32'(rsp_carryout), 32'(v.c));
         chk("rsp_zero", 32'(rsp_zero), 32'(v.z));
         rsp_ready = 1'b1;
         @(posedge clock); #1;
         rsp_ready = 1'b0;
         chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
         chk("busy_idle", 32'(busy), 32'd0);
         chk("rsp_hold", 32'(rsp_resultado), 32'(v.res));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit   got;
      int   n, nrsp, ngr;
      vec_t p0, p1;

      //            id    modo  op    a       b       res     c     z
      vecs[0] = '{1'b0, 1'b0, 3'd0, 6'd5,   6'd3,   6'd8,   1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 3'd0, 6'd31,  6'd1,   6'd32,  1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 3'd1, 6'd5,   6'd3,   6'd2,   1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 3'd0, 6'h2A,  6'h15,  6'd0,   1'b0, 1'b1};

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_ula", {ula_modo, ula_op, 12'd0, ula_a, ula_b}, 32'd0);
      chk("reset_rsp", {rsp_id, rsp_carryout, rsp_zero, 23'd0, rsp_resultado}, 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;
      chk("idle_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);

      // Directed vectors
      for (int k = 0; k < 4; k++) run_op(vecs[k]);

      // Contention from reset: strict alternation 0,1,0,1
      p0 = '{1'b0, 1'b0, 3'd0, 6'd1, 6'd1, 6'd2, 1'b0, 1'b0};
      p1 = '{1'b1, 1'b0, 3'd0, 6'd2, 6'd2, 6'd4, 1'b0, 1'b0};
      reset = 1'b1;
      drive_req(1'b0, 1'b1, p0);
      drive_req(1'b1, 1'b1, p1);
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      nrsp = 0;
      ngr  = 0;
      for (int i = 0; i < 60 && nrsp < 4; i++) begin
         @(negedge clock);
         if (req0_ready || req1_ready) begin
            chk("cont_one_hot", 32'(req0_ready & req1_ready), 32'd0);
            chk("cont_grant_order", 32'(req1_ready), 32'(ngr % 2));
            ngr++;
         end
         if (rsp_valid) begin
            chk("cont_rsp_id", 32'(rsp_id), 32'(nrsp % 2));
            chk("cont_rsp_res", 32'(rsp_resultado), (nrsp % 2) ? 32'd4 : 32'd2);
            nrsp++;
         end
      end
      chk("cont_rsp_count", 32'(nrsp), 32'd4);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (8) @(posedge clock);
      #1;
      rsp_ready = 1'b0;
      chk("cont_drained", 32'(busy), 32'd0);

      // Backpressure: response held for 5 cycles while req1 waits
      drive_req(1'b0, 1'b1, vecs[0]);
      wait_grant(1'b0, got);
      drive_req(1'b0, 1'b0, vecs[0]);
      wait_rsp(n);
      chk("bp_latency", 32'(n), 32'd3);
      drive_req(1'b1, 1'b1, vecs[2]);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rsp_stable", {rsp_id, rsp_carryout, rsp_zero, 23'd0, rsp_resultado}, 32'd8);
         chk("bp_req1_ready", 32'(req1_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      @(negedge clock);
      chk("bp_req1_granted", 32'(req1_ready), 32'd1);
      @(posedge clock); #1;
      drive_req(1'b1, 1'b0, vecs[2]);
      wait_rsp(n);
      chk("bp2_latency", 32'(n), 32'd3);
      chk("bp2_rsp", {rsp_id, rsp_carryout, rsp_zero, 23'd0, rsp_resultado}, 32'h8000_0002);
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;

      // Reset during EXEC: req0 was just granted, so pointer favours req1
      drive_req(1'b0, 1'b1, vecs[0]);
      wait_grant(1'b0, got);
      drive_req(1'b1, 1'b1, vecs[1]);
      chk("rst_pre_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ula", {ula_modo, ula_op, 12'd0, ula_a, ula_b}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rst_req0_first", {30'd0, req1_ready, req0_ready}, 32'd1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (4) begin
         @(negedge clock);
         chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
